// File: rtl/bus_arbiter_wd.sv
// rtl/bus_arbiter_wd.sv - round-robin bus arbiter with strobe watchdog
module bus_arbiter_wd #(
  parameter int N_MASTERS = 3,
  parameter int ID_W      = 2,
  parameter int TIMEOUT   = 255,
  parameter int CNT_W     = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_MASTERS-1:0] m_cyc_i,
  input  logic [N_MASTERS-1:0] m_stb_i,
  input  logic                 ack_i,
  input  logic                 err_i,
  input  logic                 clr_i,
  output logic [N_MASTERS-1:0] gnt_o,
  output logic [ID_W-1:0]      gnt_id_o,
  output logic                 busy_o,
  output logic                 to_err_o,
  output logic                 to_flag_o,
  output logic [ID_W-1:0]      to_id_o
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t               state_q;
  logic [N_MASTERS-1:0] gnt_q;
  logic [ID_W-1:0]      gnt_id_q;
  logic [ID_W-1:0]      rr_q;
  logic                 busy_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 to_err_q;
  logic                 to_flag_q;
  logic [ID_W-1:0]      to_id_q;

  logic [ID_W-1:0]      sel_d;
  logic                 found_d;
  logic [N_MASTERS-1:0] gnt_d;
  logic                 owner_cyc;
  logic                 owner_stb;
  logic                 count_en;
  logic                 fire;

  // Round-robin scan: first requester found walking upward from rr+1, wrapping.
  always_comb begin
    sel_d   = gnt_id_q;
    found_d = 1'b0;
    for (int i = 1; i <= N_MASTERS; i++) begin
      for (int j = 0; j < N_MASTERS; j++) begin
        if (!found_d && m_cyc_i[j] &&
            ((int'(rr_q) + i == j) || (int'(rr_q) + i == j + N_MASTERS))) begin
          found_d = 1'b1;
          sel_d   = ID_W'(j);
        end
      end
    end
  end

  // One-hot form of the selected master.
  always_comb begin
    gnt_d = '0;
    for (int j = 0; j < N_MASTERS; j++) begin
      if (sel_d == ID_W'(j)) gnt_d[j] = 1'b1;
    end
  end

  assign owner_cyc = m_cyc_i[gnt_id_q];
  assign owner_stb = m_stb_i[gnt_id_q];
  // A slave response in the terminal cycle stops counting, so it also suppresses the fire.
  assign count_en  = (state_q == OWN) && owner_stb && !ack_i && !err_i;
  assign fire      = count_en && (cnt_q == CNT_W'(TIMEOUT - 1));

  // Arbitration FSM, watchdog counter and sticky timeout status.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      rr_q      <= ID_W'(N_MASTERS - 1);
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      to_err_q  <= 1'b0;
      to_flag_q <= 1'b0;
      to_id_q   <= '0;
    end else begin
      to_err_q <= fire;
      if (fire) to_id_q <= gnt_id_q;
      if (clr_i) begin
        to_flag_q <= 1'b0;
      end else if (fire) begin
        to_flag_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (found_d) begin
            gnt_q    <= gnt_d;
            gnt_id_q <= sel_d;
            rr_q     <= sel_d;
            busy_q   <= 1'b1;
            state_q  <= OWN;
          end
        end
        OWN: begin
          if (!owner_cyc) begin
            // Owner released the burst: hand over directly or go idle.
            cnt_q <= '0;
            if (found_d) begin
              gnt_q    <= gnt_d;
              gnt_id_q <= sel_d;
              rr_q     <= sel_d;
            end else begin
              gnt_q   <= '0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else if (count_en && !fire) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            cnt_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_id_o  = gnt_id_q;
  assign busy_o    = busy_q;
  assign to_err_o  = to_err_q;
  assign to_flag_o = to_flag_q;
  assign to_id_o   = to_id_q;

endmodule

// File: tb/tb_bus_arbiter_wd.sv
// tb/tb_bus_arbiter_wd.sv - self-checking bench for bus_arbiter_wd
module tb_bus_arbiter_wd;
  localparam int N = 3;
  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] cyc, stb;
  logic       ack, err, clr;
  logic [2:0] gnt;
  logic [1:0] gnt_id, to_id;
  logic       busy, to_err, to_flag;

  int checks = 0;
  int errors = 0;

  bus_arbiter_wd #(.N_MASTERS(N), .ID_W(2), .TIMEOUT(T), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .m_cyc_i(cyc), .m_stb_i(stb), .ack_i(ack),
    .err_i(err), .clr_i(clr), .gnt_o(gnt), .gnt_id_o(gnt_id), .busy_o(busy),
    .to_err_o(to_err), .to_flag_o(to_flag), .to_id_o(to_id)
  );

  always #5 clk = ~clk;

  // Reference model: owner/rr as plain integers, priority by modular distance.
  bit m_busy = 0;
  int m_owner = 0, m_rr = N - 1, m_cnt = 0, m_toid = 0;
  bit m_toerr = 0, m_flag = 0;

  function automatic void model_update(bit r, logic [2:0] c, logic [2:0] s, bit a, bit e, bit cl);
    bit counting, fired;
    int pick;
    if (r) begin
      m_busy = 0; m_owner = 0; m_rr = N - 1; m_cnt = 0;
      m_toerr = 0; m_flag = 0; m_toid = 0;
      return;
    end
    counting = m_busy && s[m_owner] && !a && !e;
    fired    = counting && (m_cnt == T - 1);
    m_toerr  = fired;
    if (fired) m_toid = m_owner;
    if (cl) m_flag = 0; else if (fired) m_flag = 1;
    if (!m_busy || !c[m_owner]) begin
      pick = -1;
      for (int d = 1; d <= N; d++) begin
        if (pick < 0 && c[(m_rr + d) % N]) pick = (m_rr + d) % N;
      end
      if (pick >= 0) begin
        m_busy = 1; m_owner = pick; m_rr = pick;
      end else begin
        m_busy = 0;
      end
      m_cnt = 0;
    end else begin
      m_cnt = (counting && !fired) ? m_cnt + 1 : 0;
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input bit r, input logic [2:0] c, input logic [2:0] s,
                      input bit a, input bit e, input bit cl);
    logic [2:0] eg;
    @(negedge clk);
    rst = r; cyc = c; stb = s; ack = a; err = e; clr = cl;
    @(posedge clk);
    model_update(r, c, s, a, e, cl);
    #1;
    eg = m_busy ? 3'(1 << m_owner) : 3'b000;
    chk("mdl_gnt", int'(gnt), int'(eg));
    if (m_busy) chk("mdl_gnt_id", int'(gnt_id), m_owner);
    chk("mdl_busy", int'(busy), int'(m_busy));
    chk("mdl_to_err", int'(to_err), int'(m_toerr));
    chk("mdl_to_flag", int'(to_flag), int'(m_flag));
    chk("mdl_to_id", int'(to_id), m_toid);
    chk("inv_busy", int'(busy), int'(|gnt));
    chk("inv_onehot", int'($countones(gnt) <= 1), 1);
  endtask

  typedef struct {
    bit         rst;
    logic [2:0] cyc;
    logic [2:0] gnt;
    int         id;
    bit         busy;
  } vec_t;

  vec_t tbl[19];

  initial begin
    rst = 1'b1; cyc = '0; stb = '0; ack = 1'b0; err = 1'b0; clr = 1'b0;

    tbl[0]  = '{1'b1, 3'b000, 3'b000, 0, 1'b0};
    tbl[1]  = '{1'b0, 3'b001, 3'b001, 0, 1'b1};
    tbl[2]  = '{1'b0, 3'b001, 3'b001, 0, 1'b1};
    tbl[3]  = '{1'b0, 3'b000, 3'b000, 0, 1'b0};
    tbl[4]  = '{1'b1, 3'b000, 3'b000, 0, 1'b0};
    tbl[5]  = '{1'b0, 3'b111, 3'b001, 0, 1'b1};
    tbl[6]  = '{1'b0, 3'b111, 3'b001, 0, 1'b1};
    tbl[7]  = '{1'b0, 3'b110, 3'b010, 1, 1'b1};
    tbl[8]  = '{1'b0, 3'b111, 3'b010, 1, 1'b1};
    tbl[9]  = '{1'b0, 3'b101, 3'b100, 2, 1'b1};
    tbl[10] = '{1'b0, 3'b111, 3'b100, 2, 1'b1};
    tbl[11] = '{1'b0, 3'b011, 3'b001, 0, 1'b1};
    tbl[12] = '{1'b0, 3'b100, 3'b100, 2, 1'b1};
    tbl[13] = '{1'b0, 3'b101, 3'b100, 2, 1'b1};
    tbl[14] = '{1'b0, 3'b101, 3'b100, 2, 1'b1};
    tbl[15] = '{1'b0, 3'b001, 3'b001, 0, 1'b1};
    tbl[16] = '{1'b0, 3'b010, 3'b010, 1, 1'b1};
    tbl[17] = '{1'b0, 3'b000, 3'b000, 1, 1'b0};
    tbl[18] = '{1'b0, 3'b000, 3'b000, 1, 1'b0};

    repeat (2) @(posedge clk);

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].rst, tbl[i].cyc, 3'b000, 1'b0, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_gnt", i), int'(gnt), int'(tbl[i].gnt));
      chk($sformatf("tbl%0d_id", i), int'(gnt_id), tbl[i].id);
      chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].busy));
      if (tbl[i].rst) chk($sformatf("tbl%0d_flag", i), int'(to_flag), 0);
    end

    // Watchdog: owner 1 strobes with no response; fires every T cycles.
    step(1, 3'b000, 3'b000, 0, 0, 0);
    step(0, 3'b010, 3'b000, 0, 0, 0);
    chk("wd_grant", int'(gnt), 3'b010);
    for (int i = 1; i <= 12; i++) begin
      step(0, 3'b010, 3'b010, 0, 0, 0);
      chk($sformatf("wd_err_%0d", i), int'(to_err), int'(i % T == 0));
      chk($sformatf("wd_flag_%0d", i), int'(to_flag), int'(i >= T));
      chk($sformatf("wd_id_%0d", i), int'(to_id), (i >= T) ? 1 : 0);
    end
    step(0, 3'b010, 3'b000, 0, 0, 1);
    chk("clr_flag", int'(to_flag), 0);
    chk("clr_err", int'(to_err), 0);
    chk("clr_keep_grant", int'(gnt), 3'b010);

    // ack in the terminal cycle suppresses the fire.
    step(1, 3'b000, 3'b000, 0, 0, 0);
    step(0, 3'b010, 3'b000, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      step(0, 3'b010, 3'b010, i == 4, 0, 0);
      chk($sformatf("ack_err_%0d", i), int'(to_err), 0);
      chk($sformatf("ack_flag_%0d", i), int'(to_flag), 0);
    end

    // clr coincident with fire: flag stays 0, id still captured.
    step(1, 3'b000, 3'b000, 0, 0, 0);
    step(0, 3'b010, 3'b000, 0, 0, 0);
    for (int i = 1; i <= 4; i++) step(0, 3'b010, 3'b010, 0, 0, i == 4);
    chk("coin_err", int'(to_err), 1);
    chk("coin_flag", int'(to_flag), 0);
    chk("coin_id", int'(to_id), 1);

    // Reset mid-burst with counter at 2.
    step(1, 3'b000, 3'b000, 0, 0, 0);
    step(0, 3'b010, 3'b000, 0, 0, 0);
    step(0, 3'b010, 3'b010, 0, 0, 0);
    step(0, 3'b010, 3'b010, 0, 0, 0);
    step(1, 3'b111, 3'b010, 0, 0, 0);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(to_err), 0);
    step(0, 3'b111, 3'b000, 0, 0, 0);
    chk("rst_first_gnt", int'(gnt), 3'b001);
    chk("rst_first_id", int'(gnt_id), 0);
    for (int i = 1; i <= 4; i++) begin
      step(0, 3'b111, 3'b001, 0, 0, 0);
      chk($sformatf("rst_wd_%0d", i), int'(to_err), int'(i == 4));
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      logic [2:0] c, s;
      for (int b = 0; b < 3; b++) begin
        c[b] = ($urandom % 8) != 0;
        s[b] = ($urandom % 4) != 0;
      end
      step(($urandom % 256) == 0, c, s, ($urandom % 8) == 0,
           ($urandom % 16) == 0, ($urandom % 32) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
